vga_pixel_stream: RTL and testbench

//  Consumer of the VGA timing stage. Buffers a valid/ready pixel stream from the

---
 rtl/vga_pixel_stream.sv | 161 ++++++++++++++++
 tb/tb_vga_pixel_stream.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_stream.sv
// vga_pixel_stream
//   Consumer of the VGA timing stage. Buffers a valid/ready pixel stream in a
//   small FIFO and pops one pixel per active-video pixel strobe. Sync signals are
//   re-timed with the colour so both leave aligned. Frame alignment uses the
//   start-of-frame flag carried with each pixel; after an underflow or a
//   frame-position mismatch the block drops back to ALIGN and resynchronises.
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_pix_en                one-clk pixel strobe
//   i_de_in                 active-video flag (valid with i_pix_en)
//   i_hsync_in, i_vsync_in  sync from the timing stage (active high)
//   i_s_data, i_s_sof       upstream pixel and start-of-frame marker
//   i_s_valid, o_s_ready    upstream handshake
//   o_pix_out               registered colour
//   o_hsync_out/o_vsync_out registered sync
//   o_underflow, o_misalign sticky error flags, cleared by i_err_clr
module vga_pixel_stream #(
   parameter int unsigned    BPP       = 3,
   parameter int unsigned    DEPTH     = 16,
   parameter logic [BPP-1:0] ERR_COLOR = 3'b100
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_pix_en,
   input  logic           i_de_in,
   input  logic           i_hsync_in,
   input  logic           i_vsync_in,
   input  logic [BPP-1:0] i_s_data,
   input  logic           i_s_sof,
   input  logic           i_s_valid,
   output logic           o_s_ready,
   output logic [BPP-1:0] o_pix_out,
   output logic           o_hsync_out,
   output logic           o_vsync_out,
   output logic           o_underflow,
   output logic           o_misalign,
   input  logic           i_err_clr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {StAlign, StArmed, StRun} state_e;

   // FIFO storage: {sof, data}
   logic [BPP:0]   r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
   logic [AW:0]    r_count;

   state_e         r_state;
   logic           r_first_pix;
   logic [BPP-1:0] r_pix;
   logic           r_hsync, r_vsync, r_underflow, r_misalign;

   logic           w_full, w_empty, w_push, w_pop;
   logic [BPP:0]   w_head;
   logic           w_head_sof;
   logic [BPP-1:0] w_head_data;

   assign w_full      = (r_count == CntFull);
   assign w_empty     = (r_count == '0);
   assign w_head      = r_mem[r_rd_ptr];
   assign w_head_sof  = w_head[BPP];
   assign w_head_data = w_head[BPP-1:0];
   assign o_s_ready   = i_rst_n && !w_full;
   assign w_push      = i_s_valid && o_s_ready;

   // ALIGN discards non-sof heads every clk; RUN pops only a correctly placed pixel.
   always_comb begin
      w_pop = 1'b0;
      case (r_state)
         StAlign: w_pop = !w_empty && !w_head_sof;
         StRun:   w_pop = i_pix_en && i_de_in && !w_empty && (r_first_pix == w_head_sof);
         default: w_pop = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {i_s_sof, i_s_data};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StAlign;
         r_first_pix <= 1'b0;
         r_pix       <= '0;
         r_hsync     <= 1'b0;
         r_vsync     <= 1'b0;
         r_underflow <= 1'b0;
         r_misalign  <= 1'b0;
      end else begin
         // Clear first so a same-clk set (assigned later) wins.
         if (i_err_clr) begin
            r_underflow <= 1'b0;
            r_misalign  <= 1'b0;
         end
         if (i_pix_en) begin
            r_hsync <= i_hsync_in;
            r_vsync <= i_vsync_in;
         end
         case (r_state)
            StAlign: begin
               if (i_pix_en) r_pix <= '0;
               if (!w_empty && w_head_sof) r_state <= StArmed;
            end
            StArmed: begin
               if (i_pix_en) begin
                  r_pix <= '0;
                  if (i_vsync_in) begin
                     r_state     <= StRun;
                     r_first_pix <= 1'b1;
                  end
               end
            end
            StRun: begin
               if (i_pix_en) begin
                  if (i_de_in) begin
                     if (w_empty) begin
                        r_pix       <= ERR_COLOR;
                        r_underflow <= 1'b1;
                        r_state     <= StAlign;
                     end else if (r_first_pix != w_head_sof) begin
                        r_pix      <= '0;
                        r_misalign <= 1'b1;
                        r_state    <= StAlign;
                     end else begin
                        r_pix       <= w_head_data;
                        r_first_pix <= 1'b0;
                     end
                  end else begin
                     r_pix <= '0;
                  end
                  // Any strobe inside vsync re-arms the first-pixel expectation.
                  if (i_vsync_in) r_first_pix <= 1'b1;
               end
            end
            default: r_state <= StAlign;
         endcase
      end
   end

   assign o_pix_out   = r_pix;
   assign o_hsync_out = r_hsync;
   assign o_vsync_out = r_vsync;
   assign o_underflow = r_underflow;
   assign o_misalign  = r_misalign;

endmodule

// File: tb/tb_vga_pixel_stream.sv
module tb_vga_pixel_stream;

   localparam int BPP = 3;
   localparam int DEPTH = 16;
   localparam logic [2:0] ERR_COLOR = 3'b100;
   // Reduced raster so many frames fit in a short run.
   localparam int HA = 16, HT = 24, HS0 = 18, HS1 = 21;
   localparam int VA = 6,  VT = 10, VS0 = 7,  VS1 = 9;
   localparam int FRAME_CLKS = HT * VT * 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pix_en = 1'b0, de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
   logic [2:0] s_data = '0;
   logic       s_sof = 1'b0, s_valid = 1'b0, err_clr = 1'b0;
   logic       s_ready, hsync_out, vsync_out, underflow, misalign;
   logic [2:0] pix_out;

   always #5 clk = ~clk;

   vga_pixel_stream #(
      .BPP       (BPP),
      .DEPTH     (DEPTH),
      .ERR_COLOR (ERR_COLOR)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_pix_en    (pix_en),
      .i_de_in     (de_in),
      .i_hsync_in  (hsync_in),
      .i_vsync_in  (vsync_in),
      .i_s_data    (s_data),
      .i_s_sof     (s_sof),
      .i_s_valid   (s_valid),
      .o_s_ready   (s_ready),
      .o_pix_out   (pix_out),
      .o_hsync_out (hsync_out),
      .o_vsync_out (vsync_out),
      .o_underflow (underflow),
      .o_misalign  (misalign),
      .i_err_clr   (err_clr)
   );

   typedef struct packed {logic sof; logic [2:0] data;} ent_t;

   ent_t pq[$];   // pixels the source still has to send
   ent_t mq[$];   // reference FIFO contents

   int n_checks = 0;
   int n_fail = 0;

   // Reference model: 0 = align, 1 = armed, 2 = run
   int         m_state = 0;
   logic       m_first = 1'b0;
   logic [2:0] m_pix = '0;
   logic       m_hs = 1'b0, m_vs = 1'b0, m_uf = 1'b0, m_mis = 1'b0;

   int ph = 0, h = 0, v = 0, cur_h = 0, cur_v = 0;
   bit pause = 0, stall = 0, force_valid = 0, add_stray = 1, add_extra = 0, clr_req = 0;
   bit rst_req = 0, prev_rst = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic build_frame();
      ent_t e;
      if (add_stray) begin
         for (int i = 0; i < 3; i++) begin
            e.sof = 1'b0; e.data = 3'($urandom_range(7)); pq.push_back(e);
         end
         add_stray = 0;
      end
      for (int i = 0; i < HA * VA; i++) begin
         e.sof  = (i == 0);
         e.data = 3'(((i % HA) ^ (i / HA)) & 7);
         pq.push_back(e);
      end
      if (add_extra) begin
         for (int i = 0; i < 10; i++) begin
            e.sof = 1'b0; e.data = 3'($urandom_range(7)); pq.push_back(e);
         end
         add_extra = 0;
      end
   endtask

   task automatic drive();
      if (pq.size() < 40) build_frame();
      prev_rst = rst_n;
      rst_n    = rst_req;
      if (pause) begin
         pix_en = 1'b0;
      end else begin
         ph     = (ph + 1) % 4;
         pix_en = (ph == 0);
         if (pix_en) begin
            cur_h    = h;
            cur_v    = v;
            de_in    = (h < HA) && (v < VA);
            hsync_in = (h >= HS0) && (h < HS1);
            vsync_in = (v >= VS0) && (v < VS1);
            h++;
            if (h == HT) begin
               h = 0;
               v = (v + 1) % VT;
            end
         end
      end
      s_valid = force_valid ? 1'b1 : (!stall && ($urandom_range(3) != 0));
      if (s_valid) begin
         s_sof  = pq[0].sof;
         s_data = pq[0].data;
      end else begin
         s_sof  = 1'($urandom_range(1));
         s_data = 3'($urandom_range(7));
      end
      err_clr = clr_req;
      clr_req = 0;
   endtask

   // Predicts the effect of the coming rising edge from the inputs now applied.
   task automatic model_step();
      bit   acc;
      ent_t e;
      if (!rst_n) begin
         mq.delete();
         m_state = 0; m_first = 0; m_pix = '0;
         m_hs = 0; m_vs = 0; m_uf = 0; m_mis = 0;
         return;
      end
      acc = s_valid && (mq.size() < DEPTH);
      if (err_clr) begin
         m_uf = 0; m_mis = 0;
      end
      if (pix_en) begin
         m_hs = hsync_in; m_vs = vsync_in;
      end
      if (m_state == 0) begin
         if (pix_en) m_pix = '0;
         if (mq.size() > 0) begin
            if (!mq[0].sof) void'(mq.pop_front());
            else m_state = 1;
         end
      end else if (m_state == 1) begin
         if (pix_en) begin
            m_pix = '0;
            if (vsync_in) begin
               m_state = 2; m_first = 1;
            end
         end
      end else if (pix_en) begin
         if (de_in) begin
            if (mq.size() == 0) begin
               m_pix = ERR_COLOR; m_uf = 1; m_state = 0;
            end else if (mq[0].sof != m_first) begin
               m_pix = '0; m_mis = 1; m_state = 0;
            end else begin
               e = mq.pop_front();
               m_pix = e.data; m_first = 0;
            end
         end else begin
            m_pix = '0;
         end
         if (vsync_in) m_first = 1;
      end
      if (acc) begin
         e.sof = s_sof; e.data = s_data;
         mq.push_back(e);
         void'(pq.pop_front());
      end
   endtask

   task automatic compare();
      check_eq("pix_out", pix_out, m_pix);
      check_eq("hsync_out", hsync_out, m_hs);
      check_eq("vsync_out", vsync_out, m_vs);
      check_eq("underflow", underflow, m_uf);
      check_eq("misalign", misalign, m_mis);
      check_eq("s_ready", s_ready, rst_n && (mq.size() < DEPTH));
   endtask

   task automatic tick();
      @(negedge clk);
      compare();
      drive();
      if (prev_rst && !rst_n) begin
         #1;
         check_eq("rst_pix", pix_out, 0);
         check_eq("rst_hs", hsync_out, 0);
         check_eq("rst_vs", vsync_out, 0);
         check_eq("rst_uf", underflow, 0);
         check_eq("rst_mis", misalign, 0);
         check_eq("rst_ready", s_ready, 0);
      end
      model_step();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_pos(input int vv, input int hh);
      bit found = 0;
      for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
         tick();
         if (pix_en && cur_v == vv && cur_h == hh) found = 1;
      end
      check_eq("wait_pos", found, 1);
   endtask

   initial begin
      rst_req = 0;
      run(4);
      check_eq("reset_pix", pix_out, 0);
      check_eq("reset_ready", s_ready, 0);
      rst_req = 1;
      run(3 * FRAME_CLKS);
      check_eq("clean_uf", underflow, 0);
      check_eq("clean_mis", misalign, 0);

      // Starve the FIFO mid-frame.
      wait_pos(2, 4);
      stall = 1;
      run(160);
      stall = 0;
      check_eq("uf_set", underflow, 1);
      run(2 * FRAME_CLKS);
      check_eq("uf_no_mis", misalign, 0);
      clr_req = 1;
      run(2);
      check_eq("uf_clr", underflow, 0);

      // A frame carrying 10 surplus pixels.
      add_extra = 1;
      run(5 * FRAME_CLKS);
      check_eq("mis_set", misalign, 1);
      check_eq("mis_no_uf", underflow, 0);
      clr_req = 1;
      run(2);
      check_eq("mis_clr", misalign, 0);
      check_eq("mis_clr_uf", underflow, 0);

      // Freeze strobes with the source pushing, then reset mid-line.
      wait_pos(3, 2);
      pause = 1;
      force_valid = 1;
      run(40);
      check_eq("full_ready", s_ready, 0);
      rst_req = 0;
      run(1);
      pause = 0;
      force_valid = 0;
      run(5);
      rst_req = 1;
      run(3 * FRAME_CLKS);
      check_eq("end_uf", underflow, 0);
      check_eq("end_mis", misalign, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
